// File: rtl/sram_wr_queue.sv
// Write-side requester for one register-file SRAM write port: a two-lane in-order
// circular queue drained one entry per cycle, with forwarding of pending writes.
module sram_wr_queue #(
    parameter int SRAM_INDEX = 4,
    parameter int SRAM_WIDTH = 8,
    parameter int QDEPTH     = 8,
    parameter int QINDEX     = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid_i,
    input  logic [SRAM_INDEX-1:0] req0_addr_i,
    input  logic [SRAM_WIDTH-1:0] req0_data_i,
    input  logic                  req1_valid_i,
    input  logic [SRAM_INDEX-1:0] req1_addr_i,
    input  logic [SRAM_WIDTH-1:0] req1_data_i,
    output logic                  req_ready_o,
    input  logic                  drain_en_i,
    output logic                  we_o,
    output logic [SRAM_INDEX-1:0] addrwr_o,
    output logic [SRAM_WIDTH-1:0] datawr_o,
    input  logic [SRAM_INDEX-1:0] rd_addr_i,
    output logic                  rd_hit_o,
    output logic [SRAM_WIDTH-1:0] rd_data_o,
    output logic [QINDEX:0]       count_o,
    output logic                  empty_o
);

    localparam logic [QINDEX:0]   READY_MAX = (QINDEX+1)'(QDEPTH - 2);
    localparam logic [QINDEX-1:0] ONE_IDX   = QINDEX'(1);

    logic [SRAM_INDEX-1:0] mem_addr [QDEPTH];
    logic [SRAM_WIDTH-1:0] mem_data [QDEPTH];
    logic [QINDEX-1:0]     head;
    logic [QINDEX-1:0]     tail;

    logic            acc0;
    logic            acc1;
    logic            pop;
    logic [QINDEX:0] n_acc;
    logic [QINDEX:0] n_pop;

    // Readiness looks only at the registered count so a full queue never relies on this cycle's pop.
    assign req_ready_o = (count_o <= READY_MAX);
    assign acc0        = req0_valid_i && req_ready_o;
    assign acc1        = req1_valid_i && req_ready_o;
    assign pop         = drain_en_i && (count_o != '0);
    assign n_acc       = (QINDEX+1)'(acc0) + (QINDEX+1)'(acc1);
    assign n_pop       = (QINDEX+1)'(pop);
    assign empty_o     = (count_o == '0) && !we_o;

    // Queue storage carries no reset; only entries between head and tail are meaningful.
    always_ff @(posedge clk) begin
        if (acc0) begin
            mem_addr[tail] <= req0_addr_i;
            mem_data[tail] <= req0_data_i;
        end
        if (acc1) begin
            mem_addr[acc0 ? tail + ONE_IDX : tail] <= req1_addr_i;
            mem_data[acc0 ? tail + ONE_IDX : tail] <= req1_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            count_o  <= '0;
            we_o     <= 1'b0;
            addrwr_o <= '0;
            datawr_o <= '0;
        end else begin
            tail    <= tail + n_acc[QINDEX-1:0];
            count_o <= count_o + n_acc - n_pop;
            if (pop) begin
                we_o     <= 1'b1;
                addrwr_o <= mem_addr[head];
                datawr_o <= mem_data[head];
                head     <= head + ONE_IDX;
            end else begin
                we_o <= 1'b0;
            end
        end
    end

    // Scan oldest to youngest so the last match wins; the output register is oldest of all.
    always_comb begin
        rd_hit_o  = 1'b0;
        rd_data_o = '0;
        if (we_o && (addrwr_o == rd_addr_i)) begin
            rd_hit_o  = 1'b1;
            rd_data_o = datawr_o;
        end
        for (int i = 0; i < QDEPTH; i++) begin
            if (((QINDEX+1)'(i) < count_o) &&
                (mem_addr[head + QINDEX'(i)] == rd_addr_i)) begin
                rd_hit_o  = 1'b1;
                rd_data_o = mem_data[head + QINDEX'(i)];
            end
        end
    end

endmodule
